// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch: instruction fetch stage of the 8-bit CPU.
//
// Owns the program counter and fetches one instruction byte per request from
// instruction memory over a req/ack handshake. Fetched bytes are buffered and
// presented to the decode FSM over a valid/ready handshake. A redirect flushes
// the buffer and restarts fetching at redirect_pc.
//
// Build option:
//   IFETCH_PREFETCH_EN  defined   -> DEPTH-entry circular prefetch buffer
//                       undefined -> single instruction register
//
// Parameters:
//   AW        program counter / instruction memory address width
//   RESET_PC  PC loaded on reset
//   DEPTH     prefetch buffer entries (power of 2, >= 2), prefetch build only
//
// Ports:
//   clk, rst      clock (posedge) and asynchronous active-high reset
//   mem_req       fetch request, held until mem_ack
//   mem_addr      fetch address, stable while mem_req is high
//   mem_ack       memory completes the request this cycle
//   mem_rdata     instruction byte returned with mem_ack
//   instr         instruction at buffer head
//   instr_pc      address the head instruction was fetched from
//   instr_valid   head entry valid
//   instr_ready   decode accepts the head this cycle
//   redirect      flush and restart fetch at redirect_pc
//   redirect_pc   new fetch address
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int unsigned   AW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int unsigned   DEPTH    = 2
) (
  input  logic          clk,
  input  logic          rst,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [7:0]    mem_rdata,
  output logic [7:0]    instr,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StFlushWait
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [AW-1:0] pc_inc;
  logic          push;
  logic          pop;
  // A slot is still free once this cycle's push and pop have been applied.
  logic          slot_free;

  // ---------------------------------------------------------------------------
  // Instruction storage
  // ---------------------------------------------------------------------------
`ifdef IFETCH_PREFETCH_EN
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [7:0]    buf_data_q [DEPTH];
  logic [AW-1:0] buf_pc_q   [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_after;

  assign instr_valid = (count_q != '0);
  assign instr       = buf_data_q[rd_ptr_q];
  assign instr_pc    = buf_pc_q[rd_ptr_q];

  assign count_after = count_q + CW'(push) - CW'(pop);
  assign slot_free   = (count_after < CW'(DEPTH));

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_data_q[i] <= '0;
        buf_pc_q[i]   <= '0;
      end
    end else if (redirect) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        buf_data_q[wr_ptr_q] <= mem_rdata;
        buf_pc_q[wr_ptr_q]   <= mem_addr_q;
        wr_ptr_q             <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_after;
    end
  end
`else
  // The single IR acts as a one-entry buffer; DEPTH has no effect here.
  localparam int unsigned IrSlots = (DEPTH > 0) ? 1 : 1;

  logic [7:0]    ir_q;
  logic [AW-1:0] ir_pc_q;
  logic          ir_valid_q;
  logic [1:0]    occ_after;

  assign instr_valid = ir_valid_q;
  assign instr       = ir_q;
  assign instr_pc    = ir_pc_q;

  assign occ_after = 2'(ir_valid_q) + 2'(push) - 2'(pop);
  assign slot_free = (occ_after < 2'(IrSlots));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else if (redirect) begin
      ir_valid_q <= 1'b0;
    end else if (push) begin
      ir_q       <= mem_rdata;
      ir_pc_q    <= mem_addr_q;
      ir_valid_q <= 1'b1;
    end else if (pop) begin
      ir_valid_q <= 1'b0;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!redirect && slot_free) begin
          state_d = StReq;
        end
      end
      StReq: begin
        // Memory cannot abort, so a redirect without ack keeps the request
        // open and discards its data later.
        if (redirect) begin
          state_d = mem_ack ? StIdle : StFlushWait;
        end else if (mem_ack) begin
          state_d = slot_free ? StReq : StIdle;
        end
      end
      StFlushWait: begin
        if (mem_ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_req    = (state_q != StIdle);
    push       = (state_q == StReq) && mem_ack && !redirect;
    pop        = instr_valid && instr_ready && !redirect;
    pc_inc     = pc_q + AW'(1);
    pc_d       = pc_q;
    mem_addr_d = mem_addr_q;

    if (redirect) begin
      pc_d = redirect_pc;
    end else if (push) begin
      pc_d = pc_inc;
    end

    // mem_addr only moves when a new request starts, so it stays stable while
    // a request is outstanding.
    if (state_d == StReq) begin
      if (state_q == StIdle) begin
        mem_addr_d = pc_q;
      end else if (push) begin
        mem_addr_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      mem_addr_q <= RESET_PC;
    end else begin
      pc_q       <= pc_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch: self-checking bench for instr_fetch.
// A transaction-level scoreboard (queue of expected {instr, pc}, expected fetch
// pc and request flag) runs alongside directed sequences and random traffic.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

`ifdef IFETCH_PREFETCH_EN
  localparam int EFF = 2;
`else
  localparam int EFF = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic [7:0] instr;
  logic [7:0] instr_pc;
  logic       instr_valid;
  logic       instr_ready;
  logic       redirect;
  logic [7:0] redirect_pc;

  logic       rst_fe;
  logic       mem_req_fe;
  logic [7:0] mem_addr_fe;
  logic       ack_fe;
  logic [7:0] rdata_fe;
  logic [7:0] instr_fe;
  logic [7:0] instr_pc_fe;
  logic       valid_fe;
  logic       ready_fe;
  logic       redirect_fe;
  logic [7:0] redirect_pc_fe;

  always #5 clk = ~clk;

  instr_fetch #(.AW(8), .RESET_PC(8'h00), .DEPTH(2)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc)
  );

  instr_fetch #(.AW(8), .RESET_PC(8'hFE), .DEPTH(2)) u_dut_fe (
    .clk        (clk),
    .rst        (rst_fe),
    .mem_req    (mem_req_fe),
    .mem_addr   (mem_addr_fe),
    .mem_ack    (ack_fe),
    .mem_rdata  (rdata_fe),
    .instr      (instr_fe),
    .instr_pc   (instr_pc_fe),
    .instr_valid(valid_fe),
    .instr_ready(ready_fe),
    .redirect   (redirect_fe),
    .redirect_pc(redirect_pc_fe)
  );

  typedef struct {
    logic [7:0] data;
    logic [7:0] pc;
  } ent_t;

  typedef struct {
    logic [7:0] mem_data;
    logic [7:0] exp_instr;
    logic [7:0] exp_pc;
  } vec_t;

  vec_t       vecs [4];
  logic [7:0] fe_exp [4];
  logic [7:0] fe_addrs [4];
  int         fe_n;

  logic [7:0] mem [256];
  ent_t       q [$];
  ent_t       obs [$];

  int         tests;
  int         fails;

  logic       m_req;
  logic       m_discard;
  logic [7:0] m_pc;
  logic [7:0] m_flush_addr;
  int         acc_cnt;
  logic [7:0] last_acc_addr;
  int         wait_cnt;
  int         ack_mode;   // 0 never, 1 always, 2 random, 3 after 3 waiting cycles
  bit         rand_mode;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_req     = 1'b0;
    m_discard = 1'b0;
    m_pc      = 8'h00;
    wait_cnt  = 0;
  endtask

  // Called at a negedge: check DUT against the scoreboard, pick inputs for the
  // coming posedge, advance the scoreboard, wait for the next negedge.
  task automatic step();
    bit pop_m;
    bit push_m;
    bit nreq;
    bit ndisc;
    int sz;

    chk("instr_valid", instr_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("instr", instr, q[0].data);
      chk("instr_pc", instr_pc, q[0].pc);
    end
    chk("mem_req", mem_req, m_req);
    if (m_req) chk("mem_addr", mem_addr, m_discard ? m_flush_addr : m_pc);

    if (rand_mode) begin
      instr_ready = ($urandom_range(9) < 6);
      redirect    = ($urandom_range(19) == 0);
      redirect_pc = 8'($urandom);
    end
    case (ack_mode)
      0:       mem_ack = 1'b0;
      1:       mem_ack = 1'b1;
      2:       mem_ack = 1'($urandom_range(1));
      default: begin
        if (m_req) begin
          mem_ack  = (wait_cnt == 3);
          wait_cnt = (wait_cnt == 3) ? 0 : wait_cnt + 1;
        end else begin
          mem_ack  = 1'b0;
          wait_cnt = 0;
        end
      end
    endcase
    mem_rdata = mem[mem_addr];

    if (instr_valid && instr_ready && !redirect) obs.push_back('{instr, instr_pc});

    pop_m  = (q.size() > 0) && instr_ready && !redirect;
    push_m = m_req && mem_ack && !m_discard && !redirect;
    sz     = q.size() - (pop_m ? 1 : 0);
    if (!m_req)                       nreq = !redirect && (sz < EFF);
    else if (m_discard || redirect)   nreq = !mem_ack;
    else if (mem_ack)                 nreq = (sz + 1) < EFF;
    else                              nreq = 1'b1;
    ndisc = m_req && !mem_ack && (redirect || m_discard);
    if (ndisc && !m_discard) m_flush_addr = m_pc;
    if (push_m) begin
      acc_cnt++;
      last_acc_addr = mem_addr;
    end
    if (redirect) begin
      q.delete();
    end else begin
      if (pop_m) void'(q.pop_front());
      if (push_m) q.push_back('{mem[m_pc], m_pc});
    end
    if (redirect)    m_pc = redirect_pc;
    else if (push_m) m_pc = m_pc + 8'd1;
    m_req     = nreq;
    m_discard = ndisc;

    @(negedge clk);
  endtask

  // RESET_PC = FE instance: single-cycle memory, always ready.
  initial begin
    rst_fe         = 1'b1;
    ack_fe         = 1'b1;
    rdata_fe       = 8'h00;
    ready_fe       = 1'b1;
    redirect_fe    = 1'b0;
    redirect_pc_fe = 8'h00;
    fe_n           = 0;
    repeat (2) @(negedge clk);
    rst_fe = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_req_fe && fe_n < 4) begin
        fe_addrs[fe_n] = mem_addr_fe;
        fe_n++;
      end
    end
  end

  initial begin
    int k;
    tests = 0;
    fails = 0;
    vecs[0] = '{8'h41, 8'h41, 8'h00};
    vecs[1] = '{8'h92, 8'h92, 8'h01};
    vecs[2] = '{8'hC7, 8'hC7, 8'h02};
    vecs[3] = '{8'h05, 8'h05, 8'h03};
    fe_exp[0] = 8'hFE;
    fe_exp[1] = 8'hFF;
    fe_exp[2] = 8'h00;
    fe_exp[3] = 8'h01;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) mem[i] = vecs[i].mem_data;

    rst         = 1'b1;
    mem_ack     = 1'b0;
    mem_rdata   = 8'h00;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    ack_mode    = 1;
    rand_mode   = 1'b0;
    acc_cnt     = 0;
    last_acc_addr = 8'h00;
    m_flush_addr  = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 8'h00);
    chk("rst_instr", instr, 8'h00);
    chk("rst_instr_pc", instr_pc, 8'h00);
    chk("rst_instr_valid", instr_valid, 1'b0);

    // 1: sequential fetch, single-cycle memory, always ready
    instr_ready = 1'b1;
    rst = 1'b0;
    repeat (14) step();
    chk("t1_pop_count", obs.size() >= 4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i < obs.size()) begin
        chk("t1_instr", obs[i].data, vecs[i].exp_instr);
        chk("t1_instr_pc", obs[i].pc, vecs[i].exp_pc);
      end
    end

    // 2: stalled decode fills the buffer, then fetch resumes
    instr_ready = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 8'h00;
    ack_mode    = 1;
    step();
    redirect = 1'b0;
    acc_cnt  = 0;
    repeat (8) step();
    chk("t2_acks", acc_cnt, EFF);
    chk("t2_mem_req", mem_req, 1'b0);
    chk("t2_instr", instr, 8'h41);
    chk("t2_instr_pc", instr_pc, 8'h00);
    instr_ready = 1'b1;
    acc_cnt = 0;
    k = 0;
    while (acc_cnt == 0 && k < 10) begin
      step();
      k++;
    end
    chk("t2_resumed", acc_cnt > 0, 1'b1);
    chk("t2_resume_addr", last_acc_addr, EFF);

    // 3: ack arrives after the request has waited 3 cycles
    instr_ready = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 8'h10;
    ack_mode    = 1;
    step();
    redirect = 1'b0;
    ack_mode = 3;
    step();
    chk("t3_req", mem_req, 1'b1);
    k = 0;
    while (!instr_valid && k < 10) begin
      step();
      k++;
    end
    chk("t3_latency", k, 4);
    chk("t3_instr_pc", instr_pc, 8'h10);

    // 4: redirect while a request to 8'h05 is pending
    instr_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 8'h05;
    ack_mode    = 1;
    step();
    redirect = 1'b0;
    ack_mode = 0;
    step();
    chk("t4_pending_addr", mem_addr, 8'h05);
    redirect    = 1'b1;
    redirect_pc = 8'h20;
    step();
    redirect = 1'b0;
    chk("t4_flush_valid", instr_valid, 1'b0);
    chk("t4_flush_req", mem_req, 1'b1);
    chk("t4_flush_addr", mem_addr, 8'h05);
    ack_mode = 1;
    step();
    chk("t4_drop_valid", instr_valid, 1'b0);
    chk("t4_drop_req", mem_req, 1'b0);
    step();
    chk("t4_new_req", mem_req, 1'b1);
    chk("t4_new_addr", mem_addr, 8'h20);
    step();
    chk("t4_new_valid", instr_valid, 1'b1);
    chk("t4_new_instr_pc", instr_pc, 8'h20);

    // 6: asynchronous reset in the middle of a request
    instr_ready = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 8'h30;
    ack_mode    = 1;
    step();
    redirect = 1'b0;
    ack_mode = 0;
    step();
    chk("t6_req_before", mem_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("t6_req_async", mem_req, 1'b0);
    chk("t6_valid_async", instr_valid, 1'b0);
    chk("t6_addr_async", mem_addr, 8'h00);
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    chk("t6_req_in_rst", mem_req, 1'b0);
    @(negedge clk);
    mem_ack  = 1'b0;
    rst      = 1'b0;
    ack_mode = 1;
    step();
    chk("t6_restart_req", mem_req, 1'b1);
    chk("t6_restart_addr", mem_addr, 8'h00);

    // Random traffic against the scoreboard
    rand_mode = 1'b1;
    ack_mode  = 2;
    repeat (3000) step();
    rand_mode = 1'b0;
    redirect  = 1'b0;
    step();

    // 5: RESET_PC = FE wraps through 00
    chk("t5_fetches", fe_n, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < fe_n) chk("t5_mem_addr", fe_addrs[i], fe_exp[i]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
